pe_array_sched: RTL
===================

# pe_array_sched

Sequencing controller for `pe_wrapper`, the KERNEL_SIZE×KERNEL_SIZE systolic convolution array. It runs one job per `start`:
- latches the weight set and column count;
- waits for the array's `ready`;
- streams input columns from an upstream valid/ready source into the array;
- drives the array's drain phase;
- forwards every `dataOut_done` beat downstream and reports job completion and timeout.

It sits between the input line buffer and `pe_wrapper` and is the only block that drives the array's `en`, `dataIn` and `weightsIn`.

## Interface
Parameters:
- KERNEL_SIZE, 3, array dimension.
- DATA_WIDTH, 8, input element width.
- WEIGHT_WIDTH, 8, weight width.
- COL_W, 16, width of the column counter and `num_cols`.
- DRAIN_TIMEOUT, 32, maximum drain cycles before the job is aborted.
- SUM_WIDTH (localparam) = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- num_cols  in  COL_W  number of input columns in the job; sampled with `start`.
- weights_cfg  in  WEIGHT_WIDTH·K·K  weight set; sampled with `start`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  set on timeout or on a zero-column job; cleared at the next accepted `start`.
- in_valid  in  1  upstream column valid.
- in_data  in  DATA_WIDTH·K  upstream column.
- in_ready  out  1  high exactly when state = FEED.
- pe_en  out  1  drives `pe_wrapper.en`.
- pe_dataIn  out  DATA_WIDTH·K  drives `pe_wrapper.dataIn`.
- pe_weightsIn  out  WEIGHT_WIDTH·K·K  drives `pe_wrapper.weightsIn`; holds the latched weight set.
- pe_ready  in  1  from `pe_wrapper.ready`.
- pe_dataOut  in  SUM_WIDTH·K  from `pe_wrapper.dataOut`.
- pe_done  in  1  from `pe_wrapper.dataOut_done`.
- out_valid  out  1  result beat valid; no backpressure.
- out_data  out  SUM_WIDTH·K  result beat.

## Operation
States: IDLE, WAIT_RDY, FEED, DRAIN, DONE.

- **IDLE**
  - `start` with `num_cols` ≠ 0: latch `num_cols` and `weights_cfg`, clear `err` and all counters, go to WAIT_RDY.
  - `start` with `num_cols` = 0: set `err`, go to DONE.
  - `start` in any other state is ignored.
- **WAIT_RDY**
  - `pe_en` = 0.
  - Go to FEED on the first cycle `pe_ready` = 1.
- **FEED**
  - Accept is `in_valid & in_ready`.
  - On accept: `pe_dataIn` ← `in_data`, `pe_en` ← 1, `col_cnt`++.
  - Without accept: `pe_en` ← 0 and `pe_dataIn` holds. This is an array bubble; `pe_wrapper` freezes while `en` = 0.
  - The accept that makes `col_cnt` = `num_cols` moves to DRAIN on the same edge, so `in_ready` drops in the following cycle.
- **DRAIN**
  - `pe_en` ← 1, `pe_dataIn` ← 0, `drain_cnt`++.
  - Go to DONE when `out_cnt` = `num_cols` + KERNEL_SIZE − 1.
  - Otherwise, when `drain_cnt` = DRAIN_TIMEOUT, set `err` and go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, `pe_en` ← 0, then go to IDLE.

Output path:
- `out_cnt` increments on every `pe_done` seen in FEED or DRAIN; it saturates at its maximum.
- `pe_done` in IDLE, WAIT_RDY or DONE is neither counted nor forwarded.
- If the final expected beat and the timeout fall in the same cycle, completion wins: `err` stays 0.
- `col_cnt` and `out_cnt` are COL_W+1 bits wide, so `num_cols` + KERNEL_SIZE − 1 cannot wrap.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `in_ready`, `pe_en`, `out_valid` = 0; `pe_dataIn`, `pe_weightsIn`, `out_data` = 0; all counters 0.
- Reset asserted mid-job aborts the job immediately: no `done` pulse, and all outputs return to reset values on the next edge.
- `start` → `busy`: 1 cycle.
- `start` → first `in_ready`: 2 cycles minimum, when `pe_ready` is already high.
- Input accept → `pe_en`/`pe_dataIn` at the array: 1 cycle, registered.
- `pe_done`/`pe_dataOut` → `out_valid`/`out_data`: 1 cycle, registered copy.
- With no bubbles, N columns take N consecutive `pe_en` = 1 cycles in FEED, followed by continuous `pe_en` = 1 in DRAIN.
- Job end: `done` asserts 2 cycles after the cycle carrying the final counted `pe_done` (DRAIN→DONE on the next edge, then `done` registered); `busy` falls in the cycle after `done`.

## Test plan
- Basic job: weights all r+1 per row; `num_cols` = 5; columns [i, i+1, i+2] for i = 0..4 with `in_valid` always high; behavioural array stub with latency 2·(K−1)+1 → `pe_en` high for 5 consecutive FEED cycles, exactly 7 `out_valid` beats each equal to the stub output delayed 1 cycle, one `done` pulse, `err` = 0.
- Bubbles: same job with `in_valid` low on every other cycle → `pe_en` mirrors accepts, no column lost or duplicated, 7 output beats, `done` once.
- Late ready: hold `pe_ready` = 0 for 10 cycles after `start` → `in_ready` = 0 and `pe_en` = 0 throughout; FEED entered on the cycle after `pe_ready` rises.
- Timeout: stub emits only 4 `pe_done` beats → `done` after DRAIN_TIMEOUT = 32 drain cycles, `err` = 1; the next `start` clears `err`.
- Corner starts: `num_cols` = 0 → `done` and `err` without any `pe_en`; `start` pulsed while `busy` → ignored, latched `num_cols` unchanged.
- Reset mid-FEED after 2 columns: drive `rstn` = 0 for one cycle → all outputs 0, no `done`; a fresh job then completes normally.

Source files
------------

// File: rtl/pe_array_sched.sv
// rtl/pe_array_sched.sv - job sequencer feeding and draining the pe_wrapper systolic array
module pe_array_sched #(
    parameter int KERNEL_SIZE   = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int COL_W         = 16,
    parameter int DRAIN_TIMEOUT = 32,
    localparam int SUM_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          start,
    input  logic [COL_W-1:0]                              num_cols,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weights_cfg,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err,
    input  logic                                          in_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]             in_data,
    output logic                                          in_ready,
    output logic                                          pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0]             pe_dataIn,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] pe_weightsIn,
    input  logic                                          pe_ready,
    input  logic [SUM_WIDTH*KERNEL_SIZE-1:0]              pe_dataOut,
    input  logic                                          pe_done,
    output logic                                          out_valid,
    output logic [SUM_WIDTH*KERNEL_SIZE-1:0]              out_data
);
    localparam int DTW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [COL_W:0] OUT_EXTRA = (COL_W+1)'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_FEED, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    // One extra bit so num_cols + KERNEL_SIZE - 1 never wraps.
    logic [COL_W:0]   cols_q;
    logic [COL_W:0]   col_cnt;
    logic [COL_W:0]   out_cnt;
    logic [DTW-1:0]   drain_cnt;
    logic             accept;
    logic             last_col;
    logic             all_out;
    logic             timeout_hit;
    logic             beat;

    assign accept      = in_valid && (state == S_FEED);
    assign last_col    = accept && ((col_cnt + 1'b1) == cols_q);
    assign all_out     = (out_cnt == (cols_q + OUT_EXTRA));
    // drain_cnt counts completed drain cycles, so this fires in the last allowed one.
    assign timeout_hit = (drain_cnt == DTW'(DRAIN_TIMEOUT - 1));
    assign beat        = pe_done && ((state == S_FEED) || (state == S_DRAIN));

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        in_ready  = (state == S_FEED);
        case (state)
            S_IDLE:     if (start) state_nxt = (num_cols == '0) ? S_DONE : S_WAIT_RDY;
            S_WAIT_RDY: if (pe_ready) state_nxt = S_FEED;
            S_FEED:     if (last_col) state_nxt = S_DRAIN;
            S_DRAIN:    if (all_out || timeout_hit) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cols_q       <= '0;
            col_cnt      <= '0;
            out_cnt      <= '0;
            drain_cnt    <= '0;
            pe_weightsIn <= '0;
            pe_dataIn    <= '0;
            pe_en        <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            state     <= state_nxt;
            done      <= (state_nxt == S_DONE);
            out_valid <= beat;
            if (beat) begin
                out_data <= pe_dataOut;
                if (out_cnt != '1) out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    pe_en <= 1'b0;
                    if (start) begin
                        err       <= (num_cols == '0);
                        col_cnt   <= '0;
                        out_cnt   <= '0;
                        drain_cnt <= '0;
                        if (num_cols != '0) begin
                            cols_q       <= {1'b0, num_cols};
                            pe_weightsIn <= weights_cfg;
                        end
                    end
                end
                S_WAIT_RDY: pe_en <= 1'b0;
                S_FEED: begin
                    // A missing column is a bubble: the array freezes while en is low.
                    pe_en <= accept;
                    if (accept) begin
                        pe_dataIn <= in_data;
                        col_cnt   <= col_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    pe_en     <= 1'b1;
                    pe_dataIn <= '0;
                    drain_cnt <= drain_cnt + 1'b1;
                    if (!all_out && timeout_hit) err <= 1'b1;
                end
                default: pe_en <= 1'b0;
            endcase
        end
    end
endmodule
